// File: rtl/chromosome_evaluator.sv
// Chromosome fitness evaluator: drives a vector table into an external phenotype,
// samples its outputs per vector and accumulates saturating per-channel error sums.
module chromosome_evaluator #(
  parameter int IN_WIDTH      = 8,
  parameter int OUT_WIDTH     = 8,
  parameter int MAX_SEQ       = 16,
  parameter int IDX_WIDTH     = 4,
  parameter int CYC_WIDTH     = 16,
  parameter int SUM_WIDTH     = 32,
  parameter int IGNORE_CYCLES = 5,
  parameter int ZERO_CYCLES   = 1
) (
  input  logic                           iClock,
  input  logic                           iReset,
  input  logic [MAX_SEQ*IN_WIDTH-1:0]    iInputSequence,
  input  logic [MAX_SEQ*OUT_WIDTH-1:0]   iExpectedOutput,
  input  logic [MAX_SEQ*OUT_WIDTH-1:0]   iValidOutput,
  input  logic [IDX_WIDTH:0]             iSequenceCount,
  input  logic [CYC_WIDTH-1:0]           iCyclesPerVector,
  input  logic                           iErrorMode,
  input  logic                           iStart,
  input  logic                           iAck,
  input  logic                           iStall,
  input  logic                           iAbort,
  input  logic [OUT_WIDTH-1:0]           iChromOutput,
  output logic [IN_WIDTH-1:0]            oChromInput,
  output logic                           oChromZero,
  output logic                           oReady,
  output logic                           oDone,
  output logic [OUT_WIDTH*SUM_WIDTH-1:0] oErrorSums,
  output logic [IDX_WIDTH-1:0]           oVectorIndex,
  output logic [2:0]                     oState
);

  // Handshake: iStart is accepted only while oReady; results are held while oDone
  // until iAck is sampled high; iAbort returns any busy state to IDLE.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PROCESSING = 3'd1,
    DONE       = 3'd2,
    STALLED    = 3'd3,
    INPUT_WAIT = 3'd4,
    ZEROING    = 3'd5
  } state_t;

  localparam int EXT_W = ((SUM_WIDTH > CYC_WIDTH) ? SUM_WIDTH : CYC_WIDTH) + 1;
  localparam logic [IDX_WIDTH:0]   MAX_COUNT = (IDX_WIDTH+1)'(MAX_SEQ);
  localparam logic [IDX_WIDTH:0]   CNT_ONE   = (IDX_WIDTH+1)'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE   = IDX_WIDTH'(1);
  localparam logic [CYC_WIDTH-1:0] CYC_ONE   = CYC_WIDTH'(1);
  localparam logic [CYC_WIDTH-1:0] CYC_MAX   = '1;
  localparam logic [CYC_WIDTH-1:0] IGNORE_C  = CYC_WIDTH'(IGNORE_CYCLES);
  localparam logic [CYC_WIDTH-1:0] ZERO_LAST = CYC_WIDTH'(ZERO_CYCLES - 1);
  localparam logic [SUM_WIDTH-1:0] SUM_MAX   = '1;

  state_t state, stateNext;

  logic [IDX_WIDTH:0]   seqCount;
  logic [CYC_WIDTH-1:0] cyclesPerVector;
  logic                 errorMode;
  logic [IDX_WIDTH-1:0] vectorIndex;
  logic [CYC_WIDTH-1:0] cycleCount;
  logic [CYC_WIDTH-1:0] zeroCount;
  logic [CYC_WIDTH-1:0] acc      [OUT_WIDTH];
  logic [CYC_WIDTH-1:0] accNext  [OUT_WIDTH];
  logic [SUM_WIDTH-1:0] sums     [OUT_WIDTH];
  logic [SUM_WIDTH-1:0] sumsNext [OUT_WIDTH];

  logic [IN_WIDTH-1:0]  inVec    [MAX_SEQ];
  logic [OUT_WIDTH-1:0] expVec   [MAX_SEQ];
  logic [OUT_WIDTH-1:0] validVec [MAX_SEQ];

  logic [IDX_WIDTH:0]   startCount;
  logic [CYC_WIDTH-1:0] startCycles;
  logic [OUT_WIDTH-1:0] mismatch;
  logic                 sampleEn;
  logic                 lastCycle;
  logic                 lastVector;

  genvar gk;
  for (gk = 0; gk < MAX_SEQ; gk++) begin : gUnpack
    assign inVec[gk]    = iInputSequence[gk*IN_WIDTH +: IN_WIDTH];
    assign expVec[gk]   = iExpectedOutput[gk*OUT_WIDTH +: OUT_WIDTH];
    assign validVec[gk] = iValidOutput[gk*OUT_WIDTH +: OUT_WIDTH];
  end

  for (gk = 0; gk < OUT_WIDTH; gk++) begin : gPack
    assign oErrorSums[gk*SUM_WIDTH +: SUM_WIDTH] = sums[gk];
  end

  // Sum update never wraps: the addition is done one bit wider and clamped.
  function automatic logic [SUM_WIDTH-1:0] satAdd(input logic [SUM_WIDTH-1:0] a,
                                                  input logic [CYC_WIDTH-1:0] b);
    logic [EXT_W-1:0] s;
    s = EXT_W'(a) + EXT_W'(b);
    if (s > EXT_W'(SUM_MAX)) satAdd = SUM_MAX;
    else                     satAdd = s[SUM_WIDTH-1:0];
  endfunction

  always_comb begin
    startCount  = (iSequenceCount > MAX_COUNT) ? MAX_COUNT : iSequenceCount;
    startCycles = (iCyclesPerVector == '0) ? CYC_ONE : iCyclesPerVector;
    mismatch    = (iChromOutput ^ expVec[vectorIndex]) & validVec[vectorIndex];
    sampleEn    = (state == PROCESSING) && (cycleCount >= IGNORE_C);
    lastCycle   = (cycleCount == (cyclesPerVector - CYC_ONE));
    lastVector  = (({1'b0, vectorIndex} + CNT_ONE) == seqCount);
  end

  // Per-channel accumulation; the last cycle's own sample is folded into the sum.
  always_comb begin
    for (int j = 0; j < OUT_WIDTH; j++) begin
      accNext[j]  = acc[j];
      sumsNext[j] = sums[j];
      if (sampleEn && mismatch[j] && (acc[j] != CYC_MAX)) begin
        accNext[j] = acc[j] + CYC_ONE;
      end
      if ((state == PROCESSING) && lastCycle) begin
        if (errorMode) sumsNext[j] = satAdd(sums[j], accNext[j]);
        else           sumsNext[j] = satAdd(sums[j], CYC_WIDTH'(accNext[j] != '0));
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (iStart) stateNext = (startCount == '0) ? DONE : ZEROING;
      end
      ZEROING: begin
        if (zeroCount == ZERO_LAST) stateNext = INPUT_WAIT;
      end
      INPUT_WAIT: stateNext = PROCESSING;
      PROCESSING: begin
        if (lastCycle) begin
          if (lastVector) stateNext = iStall ? STALLED : DONE;
          else            stateNext = INPUT_WAIT;
        end
      end
      STALLED: begin
        if (!iStall) stateNext = DONE;
      end
      DONE: begin
        if (iAck) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (iAbort && (state != IDLE)) stateNext = IDLE;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      seqCount        <= '0;
      cyclesPerVector <= '0;
      errorMode       <= 1'b0;
      vectorIndex     <= '0;
      cycleCount      <= '0;
      zeroCount       <= '0;
      oChromInput     <= '0;
      for (int j = 0; j < OUT_WIDTH; j++) begin
        acc[j]  <= '0;
        sums[j] <= '0;
      end
    end else begin
      oChromInput <= inVec[vectorIndex];
      case (state)
        IDLE: begin
          if (iStart) begin
            seqCount        <= startCount;
            cyclesPerVector <= startCycles;
            errorMode       <= iErrorMode;
            vectorIndex     <= '0;
            zeroCount       <= '0;
            for (int j = 0; j < OUT_WIDTH; j++) sums[j] <= '0;
          end
        end
        ZEROING: zeroCount <= zeroCount + CYC_ONE;
        INPUT_WAIT: begin
          cycleCount <= '0;
          for (int j = 0; j < OUT_WIDTH; j++) acc[j] <= '0;
        end
        PROCESSING: begin
          cycleCount <= cycleCount + CYC_ONE;
          for (int j = 0; j < OUT_WIDTH; j++) begin
            acc[j]  <= accNext[j];
            sums[j] <= sumsNext[j];
          end
          if (lastCycle && !lastVector) vectorIndex <= vectorIndex + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  assign oChromZero   = (state == ZEROING);
  assign oReady       = (state == IDLE);
  assign oDone        = (state == DONE);
  assign oVectorIndex = vectorIndex;
  assign oState       = state;

endmodule

// File: tb/tb_chromosome_evaluator.sv
// Bench for chromosome_evaluator: directed scenarios plus randomized tables checked
// against a per-vector, per-cycle mismatch-counting reference model.
module tb_chromosome_evaluator;

  localparam int IGN  = 5;
  localparam int ZERO = 1;

  logic         iClock = 1'b0;
  logic         iReset;
  logic [127:0] iInputSequence;
  logic [127:0] iExpectedOutput;
  logic [127:0] iValidOutput;
  logic [4:0]   iSequenceCount;
  logic [15:0]  iCyclesPerVector;
  logic         iErrorMode;
  logic         iStart, iAck, iStall, iAbort;
  logic [7:0]   iChromOutput;

  logic [7:0]   oChromInput;
  logic         oChromZero, oReady, oDone;
  logic [255:0] oErrorSums;
  logic [3:0]   oVectorIndex;
  logic [2:0]   oState;

  logic [7:0]   chromInputS;
  logic         chromZeroS, readyS, doneS;
  logic [31:0]  errorSumsS;
  logic [3:0]   vectorIndexS;
  logic [2:0]   stateS;

  logic [7:0]   inTab    [16];
  logic [7:0]   expTab   [16];
  logic [7:0]   validTab [16];
  logic [1:0]   faultSel = 2'd0;
  logic [15:0]  phaseCnt = 16'd0;

  logic [31:0]  exp_q[$];
  int           testsRun  = 0;
  int           failCount = 0;

  chromosome_evaluator dut (
    .iClock(iClock), .iReset(iReset),
    .iInputSequence(iInputSequence), .iExpectedOutput(iExpectedOutput),
    .iValidOutput(iValidOutput), .iSequenceCount(iSequenceCount),
    .iCyclesPerVector(iCyclesPerVector), .iErrorMode(iErrorMode),
    .iStart(iStart), .iAck(iAck), .iStall(iStall), .iAbort(iAbort),
    .iChromOutput(iChromOutput),
    .oChromInput(oChromInput), .oChromZero(oChromZero), .oReady(oReady),
    .oDone(oDone), .oErrorSums(oErrorSums), .oVectorIndex(oVectorIndex),
    .oState(oState)
  );

  chromosome_evaluator #(.SUM_WIDTH(4)) dutSat (
    .iClock(iClock), .iReset(iReset),
    .iInputSequence(iInputSequence), .iExpectedOutput(iExpectedOutput),
    .iValidOutput(iValidOutput), .iSequenceCount(iSequenceCount),
    .iCyclesPerVector(iCyclesPerVector), .iErrorMode(iErrorMode),
    .iStart(iStart), .iAck(iAck), .iStall(iStall), .iAbort(iAbort),
    .iChromOutput(iChromOutput),
    .oChromInput(chromInputS), .oChromZero(chromZeroS), .oReady(readyS),
    .oDone(doneS), .oErrorSums(errorSumsS), .oVectorIndex(vectorIndexS),
    .oState(stateS)
  );

  // ---------------- clock / environment ----------------
  always #5 iClock = ~iClock;

  always_comb begin
    iInputSequence  = '0;
    iExpectedOutput = '0;
    iValidOutput    = '0;
    for (int k = 0; k < 16; k++) begin
      iInputSequence[k*8 +: 8]  = inTab[k];
      iExpectedOutput[k*8 +: 8] = expTab[k];
      iValidOutput[k*8 +: 8]    = validTab[k];
    end
  end

  // Phenotype behaviour as a function of the expected word and cycle within the vector.
  function automatic logic [7:0] phenoOut(input logic [7:0] e, input int cyc, input logic [1:0] f);
    case (f)
      2'd0:    phenoOut = e;
      2'd1:    phenoOut = e & 8'hFB;
      2'd2:    phenoOut = (cyc < IGN) ? ~e : e;
      default: phenoOut = ~e;
    endcase
  endfunction

  always @(posedge iClock) phaseCnt <= (oState == 3'd1) ? phaseCnt + 16'd1 : 16'd0;

  always_comb iChromOutput = phenoOut(expTab[oVectorIndex], int'(phaseCnt), faultSel);

  // ---------------- reference model ----------------
  function automatic longint modelSum(input int j, input int n, input int c,
                                      input bit mode, input logic [1:0] f, input int sw);
    int     neff, ceff, cnt;
    longint s, maxv;
    logic [7:0] m;
    neff = (n > 16) ? 16 : n;
    ceff = (c == 0) ? 1 : c;
    maxv = (longint'(1) << sw) - 1;
    s = 0;
    for (int k = 0; k < neff; k++) begin
      cnt = 0;
      for (int cyc = IGN; cyc < ceff; cyc++) begin
        m = (phenoOut(expTab[k], cyc, f) ^ expTab[k]) & validTab[k];
        if (m[j]) cnt++;
      end
      s += mode ? cnt : ((cnt != 0) ? 1 : 0);
      if (s > maxv) s = maxv;
    end
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      failCount++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
    end
  endtask

  task automatic checkSums(input string tag, input int n, input int c, input bit mode, input logic [1:0] f);
    logic [31:0] e;
    for (int j = 0; j < 8; j++) exp_q.push_back(32'(modelSum(j, n, c, mode, f, 32)));
    for (int j = 0; j < 8; j++) exp_q.push_back(32'(modelSum(j, n, c, mode, f, 4)));
    for (int j = 0; j < 8; j++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_sum%0d", tag, j), oErrorSums[j*32 +: 32], e);
    end
    for (int j = 0; j < 8; j++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_sat_sum%0d", tag, j), {28'd0, errorSumsS[j*4 +: 4]}, e);
    end
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_ready"}, oReady, 1);
    check({tag, "_done"}, oDone, 0);
    check({tag, "_zero"}, oChromZero, 0);
    check({tag, "_index"}, oVectorIndex, 0);
    check({tag, "_chrom_in"}, oChromInput, 0);
    check({tag, "_state"}, oState, 0);
    for (int j = 0; j < 8; j++) check($sformatf("%s_sum%0d", tag, j), oErrorSums[j*32 +: 32], 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic randomTables(input bit allValid);
    for (int k = 0; k < 16; k++) begin
      inTab[k]    = 8'($urandom);
      expTab[k]   = 8'($urandom);
      validTab[k] = allValid ? 8'hFF : 8'($urandom);
    end
  endtask

  task automatic setup(input int n, input int c, input bit mode, input logic [1:0] f);
    iSequenceCount   = 5'(n);
    iCyclesPerVector = 16'(c);
    iErrorMode       = mode;
    faultSel         = f;
  endtask

  task automatic pulseStart();
    @(negedge iClock); iStart = 1'b1;
    @(negedge iClock); iStart = 1'b0;
  endtask

  // Runs one evaluation to DONE and checks latency. Cycle 1 is the one right after
  // the start edge, so DONE at cycle 1+ZERO+N*(C+1) is ZERO+N*(C+1) edges later.
  task automatic runEval(input string tag, input int n, input int c, input bit mode, input logic [1:0] f);
    int edges, neff, ceff, expEdges;
    neff = (n > 16) ? 16 : n;
    ceff = (c == 0) ? 1 : c;
    expEdges = (neff == 0) ? 0 : ZERO + neff * (ceff + 1);
    setup(n, c, mode, f);
    pulseStart();
    if (neff > 0) check({tag, "_chrom_zero"}, oChromZero, 1);
    edges = 0;
    while (oDone !== 1'b1 && edges < 4000) begin
      @(negedge iClock);
      edges++;
    end
    check({tag, "_done_seen"}, oDone, 1);
    check({tag, "_latency"}, edges, expEdges);
  endtask

  task automatic ackRun(input string tag);
    @(negedge iClock); iAck = 1'b1;
    @(negedge iClock); iAck = 1'b0;
    check({tag, "_ack_ready"}, oReady, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int  waitCnt, rn, rc;
    bit  doneSeen, rm;
    logic [1:0] rf;

    iReset = 1'b1; iStart = 1'b0; iAck = 1'b0; iStall = 1'b0; iAbort = 1'b0;
    setup(0, 0, 1'b0, 2'd0);
    for (int k = 0; k < 16; k++) begin
      inTab[k] = 8'd0; expTab[k] = 8'd0; validTab[k] = 8'd0;
    end
    repeat (3) @(negedge iClock);
    iReset = 1'b0;
    checkResetState("reset");

    // Echoing phenotype: no errors, nominal latency.
    randomTables(1'b1);
    runEval("echo", 4, 20, 1'b0, 2'd0);
    checkSums("echo", 4, 20, 1'b0, 2'd0);
    ackRun("echo");

    // Channel 2 stuck low, expected bit 2 high on vectors 1 and 3 only.
    for (int k = 0; k < 16; k++) expTab[k][2] = (k == 1 || k == 3);
    runEval("stuck_m0", 4, 20, 1'b0, 2'd1);
    check("stuck_m0_ch2", oErrorSums[2*32 +: 32], 2);
    checkSums("stuck_m0", 4, 20, 1'b0, 2'd1);
    ackRun("stuck_m0");
    runEval("stuck_m1", 4, 20, 1'b1, 2'd1);
    check("stuck_m1_ch2", oErrorSums[2*32 +: 32], 30);
    checkSums("stuck_m1", 4, 20, 1'b1, 2'd1);
    ackRun("stuck_m1");

    validTab[3] = 8'hFB;
    runEval("masked", 4, 20, 1'b0, 2'd1);
    check("masked_ch2", oErrorSums[2*32 +: 32], 1);
    checkSums("masked", 4, 20, 1'b0, 2'd1);
    ackRun("masked");
    validTab[3] = 8'hFF;

    // Mismatches only while the phenotype settles.
    runEval("settle", 4, 20, 1'b1, 2'd2);
    check("settle_ch0", oErrorSums[31:0], 0);
    checkSums("settle", 4, 20, 1'b1, 2'd2);
    ackRun("settle");

    // Stall holds the result back from DONE.
    iStall = 1'b1;
    setup(2, 8, 1'b1, 2'd3);
    pulseStart();
    waitCnt = 0;
    while (oState !== 3'd3 && waitCnt < 200) begin @(negedge iClock); waitCnt++; end
    check("stall_reached", oState, 3);
    for (int i = 0; i < 10; i++) begin
      check("stall_no_done", oDone, 0);
      check("stall_state", oState, 3);
      @(negedge iClock);
    end
    iStall = 1'b0;
    @(negedge iClock);
    check("stall_release_done", oDone, 1);
    iStart = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
    check("done_ignores_start", oState, 2);
    checkSums("stall", 2, 8, 1'b1, 2'd3);
    ackRun("stall");

    // Abort while vector 2 is processing keeps the partial sums of vectors 0 and 1.
    setup(4, 20, 1'b0, 2'd1);
    pulseStart();
    waitCnt = 0; doneSeen = 1'b0;
    while (!(oVectorIndex === 4'd2 && oState === 3'd1) && waitCnt < 200) begin
      @(negedge iClock); waitCnt++;
      if (oDone) doneSeen = 1'b1;
    end
    check("abort_reached_v2", oVectorIndex, 2);
    repeat (3) @(negedge iClock);
    iAbort = 1'b1;
    @(negedge iClock);
    iAbort = 1'b0;
    check("abort_idle", oState, 0);
    repeat (30) begin
      @(negedge iClock);
      if (oDone) doneSeen = 1'b1;
    end
    check("abort_no_done", doneSeen, 0);
    checkSums("abort_partial", 2, 20, 1'b0, 2'd1);

    // Zero-length sequence goes straight to DONE with cleared sums.
    runEval("count0", 0, 20, 1'b0, 2'd1);
    checkSums("count0", 0, 20, 1'b0, 2'd1);
    ackRun("count0");

    // Reset in the middle of a vector.
    setup(4, 20, 1'b1, 2'd3);
    pulseStart();
    repeat (30) @(negedge iClock);
    iReset = 1'b1;
    @(negedge iClock);
    iReset = 1'b0;
    checkResetState("mid_reset");

    // Saturation of a narrow sum with a permanently wrong phenotype.
    runEval("sat", 2, 20, 1'b1, 2'd3);
    check("sat_ch0_narrow", {28'd0, errorSumsS[3:0]}, 15);
    check("sat_ch0_wide", oErrorSums[31:0], 30);
    checkSums("sat", 2, 20, 1'b1, 2'd3);
    ackRun("sat");

    // Randomized tables and configurations, including clamp and C below the settle window.
    for (int it = 0; it < 8; it++) begin
      randomTables(1'b0);
      rn = $urandom_range(0, 20);
      rc = $urandom_range(0, 24);
      rm = 1'($urandom_range(0, 1));
      rf = 2'($urandom_range(0, 3));
      runEval($sformatf("rand%0d", it), rn, rc, rm, rf);
      checkSums($sformatf("rand%0d", it), rn, rc, rm, rf);
      ackRun($sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
